axi_ar_sid_arbiter: RTL and testbench
=====================================

# axi_ar_sid_arbiter

Round-robin arbiter that shares one AXI5 read-address (AR) channel among NUM_REQ requesters, tagging each request with its stream identifiers (SECSID/SID/SSID) for untranslated-transaction (v3) signalling. It routes R beats back to their originator by ARID prefix and enforces a per-requester outstanding-burst limit. It sits between the per-master read engines and the single AXI5 manager port of the subsystem.

## Interface
Parameters:
- NUM_REQ, 4: requester count, power of two, 2..8
- ADDR_WIDTH, 16: AR address width
- DATA_WIDTH, 32: R data width
- ID_IN_WIDTH, 2: requester-side ARID width
- ID_R_WIDTH, ID_IN_WIDTH+log2(NUM_REQ): manager-side ARID/RID width, 4 at defaults
- RRESP_WIDTH, 3: RRESP width
- SECSID_WIDTH, 1; SID_WIDTH, 3; SSID_WIDTH, 6: stream-ID field widths
- MAX_OUTST, 4: per-requester outstanding-burst limit, 1..15

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- s_arvalid / s_arready  in / out  NUM_REQ  per-requester AR handshake
- s_araddr  in  NUM_REQ×ADDR_WIDTH  address
- s_arid  in  NUM_REQ×ID_IN_WIDTH  requester ID
- s_arlen  in  NUM_REQ×8;  s_arsize  in  NUM_REQ×3;  s_arburst  in  NUM_REQ×2
- s_secsid / s_sid / s_ssid  in  per-requester field widths  stream identifiers
- s_ssidv  in  NUM_REQ  SSID valid
- m_arvalid / m_arready  out / in  1  manager AR handshake
- m_araddr, m_arid(ID_R_WIDTH), m_arlen, m_arsize, m_arburst, m_arsecsid, m_arsid, m_arssid, m_arssidv  out  registered AR payload
- m_rvalid / m_rready  in / out  1
- m_rid  in  ID_R_WIDTH;  m_rdata  in  DATA_WIDTH;  m_rresp  in  RRESP_WIDTH;  m_rlast  in  1
- s_rvalid / s_rready  out / in  NUM_REQ
- s_rid  out  ID_IN_WIDTH;  s_rdata, s_rresp, s_rlast  out  broadcast to all requesters
- err_unroutable  out  1  one-cycle pulse
- err_underflow  out  1  one-cycle pulse

## Operation
- Eligible[i] = s_arvalid[i] & (outst[i] < MAX_OUTST).
- Output register: empty or full. Load permitted when empty, or when full and m_arready=1 in the same cycle.
- On load: round-robin grant g among eligible requesters, searching from ptr upward with wrap. s_arready[g]=1 combinationally that cycle, with no other s_arready asserted. Payload is registered with m_arid={g, s_arid[g]}; ptr←g+1 mod NUM_REQ; outst[g]++.
- m_arvalid is held with a stable payload until m_arready, per the AXI rule.
- R path is combinational. idx=m_rid[ID_R_WIDTH-1:ID_IN_WIDTH]; s_rvalid[idx]=m_rvalid; m_rready=s_rready[idx]; s_rid=m_rid low bits.
- On an R handshake with m_rlast=1: outst[idx]--.
- Same-cycle increment and decrement on the same requester leaves the count unchanged.
- If idx ≥ NUM_REQ (possible only for non-power-of-two use, blocked by the parameter check): m_rready=1, the beat is dropped, err_unroutable pulses.
- RLAST with outst[idx]=0: count stays 0, err_underflow pulses.
- Counters are 4 bits, saturating, and never wrap.

## Timing
- Reset values: m_arvalid=0, all s_arready=0, s_rvalid=0, errors=0, ptr=0, all outst=0, payload registers=0.
- AR latency: s handshake at cycle N gives m_arvalid at N+1.
- Sustained throughput is 1 AR per cycle while m_arready=1.
- R latency is 0 cycles.
- Backpressure: while full and m_arready=0, no s_arready is asserted.
- Reset mid-burst: the pending AR is discarded and counters are cleared. The downstream is reset in the same domain.
- A requester at MAX_OUTST is skipped by arbitration, and ptr does not stall on it.

## Structure
- Package axi_arb_pkg holds the ar_payload_t struct (addr, id, len, size, burst, secsid, sid, ssid, ssidv) and the NUM_REQ legality check function.
- One sub-module, rr_arbiter: parameterised NUM_REQ, with req vector, ptr and update-enable in, one-hot grant out.
- Outstanding counters and R demux live in the top level.

## Test plan
- Single request: requester 2 with arid=1 and sid=5 → m_arid=0x9, m_arsid=5, and m_arvalid one cycle after the s handshake.
- All 4 requesters continuously valid, m_arready=1 → grants 0,1,2,3,0 in order, one per cycle.
- m_arready low for 5 cycles → payload stable and no s_arready; the release cycle reloads the next grant.
- Requester 1 issues 4 ARs with no RLAST → it is masked, and the others keep being granted. One RLAST on rid=0x5 → requester 1 is eligible the next cycle.
- R beat rid=0xE with s_rready[3]=0 → m_rready=0. Raise s_rready → handshake, and s_rid=2 at requester 3 only.
- RLAST to a requester with count 0 → err_underflow pulses for 1 cycle and the count stays 0. Reset asserted with a full output register → m_arvalid=0 next cycle and all counts 0.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and parameter helpers for the AXI5 AR stream-ID arbiter.
// The payload struct is sized for the default configuration of the top level.
package axi_arb_pkg;

  localparam int AR_ADDR_W   = 16;
  localparam int AR_ID_W     = 4;
  localparam int AR_SECSID_W = 1;
  localparam int AR_SID_W    = 3;
  localparam int AR_SSID_W   = 6;

  typedef struct packed {
    logic [AR_ADDR_W-1:0]   addr;
    logic [AR_ID_W-1:0]     id;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic [AR_SECSID_W-1:0] secsid;
    logic [AR_SID_W-1:0]    sid;
    logic [AR_SSID_W-1:0]   ssid;
    logic                   ssidv;
  } ar_payload_t;

  // Requester count must be a power of two so every RID prefix maps to a requester.
  function automatic bit num_req_legal(input int n);
    return (n >= 2) && (n <= 8) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/axi_ar_sid_arbiter_rr.sv
// Round-robin grant logic: searches upward from ptr with wrap and returns a one-hot grant.
// The grant is forced to zero whenever the update enable is low.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = ptr_i + PTR_W'(off);
      if (en_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_ar_sid_arbiter.sv
// Shares one AXI5 AR channel among NUM_REQ read engines with stream-ID tagging,
// routes R beats back by ARID prefix and limits outstanding bursts per requester.
module axi_ar_sid_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_IN_WIDTH  = 2,
  parameter int ID_R_WIDTH   = ID_IN_WIDTH + $clog2(NUM_REQ),
  parameter int RRESP_WIDTH  = 3,
  parameter int SECSID_WIDTH = 1,
  parameter int SID_WIDTH    = 3,
  parameter int SSID_WIDTH   = 6,
  parameter int MAX_OUTST    = 4
) (
  input  logic                             aclk_i,
  input  logic                             areset_i,
  input  logic [NUM_REQ-1:0]               s_arvalid_i,
  output logic [NUM_REQ-1:0]               s_arready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    s_araddr_i,
  input  logic [NUM_REQ*ID_IN_WIDTH-1:0]   s_arid_i,
  input  logic [NUM_REQ*8-1:0]             s_arlen_i,
  input  logic [NUM_REQ*3-1:0]             s_arsize_i,
  input  logic [NUM_REQ*2-1:0]             s_arburst_i,
  input  logic [NUM_REQ*SECSID_WIDTH-1:0]  s_secsid_i,
  input  logic [NUM_REQ*SID_WIDTH-1:0]     s_sid_i,
  input  logic [NUM_REQ*SSID_WIDTH-1:0]    s_ssid_i,
  input  logic [NUM_REQ-1:0]               s_ssidv_i,
  output logic                             m_arvalid_o,
  input  logic                             m_arready_i,
  output logic [ADDR_WIDTH-1:0]            m_araddr_o,
  output logic [ID_R_WIDTH-1:0]            m_arid_o,
  output logic [7:0]                       m_arlen_o,
  output logic [2:0]                       m_arsize_o,
  output logic [1:0]                       m_arburst_o,
  output logic [SECSID_WIDTH-1:0]          m_arsecsid_o,
  output logic [SID_WIDTH-1:0]             m_arsid_o,
  output logic [SSID_WIDTH-1:0]            m_arssid_o,
  output logic                             m_arssidv_o,
  input  logic                             m_rvalid_i,
  output logic                             m_rready_o,
  input  logic [ID_R_WIDTH-1:0]            m_rid_i,
  input  logic [DATA_WIDTH-1:0]            m_rdata_i,
  input  logic [RRESP_WIDTH-1:0]           m_rresp_i,
  input  logic                             m_rlast_i,
  output logic [NUM_REQ-1:0]               s_rvalid_o,
  input  logic [NUM_REQ-1:0]               s_rready_i,
  output logic [ID_IN_WIDTH-1:0]           s_rid_o,
  output logic [DATA_WIDTH-1:0]            s_rdata_o,
  output logic [RRESP_WIDTH-1:0]           s_rresp_o,
  output logic                             s_rlast_o,
  output logic                             err_unroutable_o,
  output logic                             err_underflow_o
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int RIDX_W = ID_R_WIDTH - ID_IN_WIDTH;

  if (!num_req_legal(NUM_REQ) || MAX_OUTST < 1 || MAX_OUTST > 15 ||
      ADDR_WIDTH != AR_ADDR_W || ID_R_WIDTH != AR_ID_W || SECSID_WIDTH != AR_SECSID_W ||
      SID_WIDTH != AR_SID_W || SSID_WIDTH != AR_SSID_W) begin : g_param_check
    $error("axi_ar_sid_arbiter: unsupported parameterisation");
  end

  ar_payload_t          arQ, arD;
  logic                 mArvalid_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [3:0]           outstCnt_q [NUM_REQ];
  logic [3:0]           outstCnt_d [NUM_REQ];
  logic                 errUnroutable_q, errUnderflow_q;

  logic [NUM_REQ-1:0]   eligible, grant;
  logic                 loadOk, anyGrant;
  logic [IDX_W-1:0]     grantIdx;
  logic [RIDX_W-1:0]    rIdx;
  logic                 routable, rReadySel, rHs, lastHs;
  logic [3:0]           rCnt;

  // Reset gates the load so no requester sees s_arready while the block is held.
  assign loadOk   = !areset_i && (!mArvalid_q || m_arready_i);
  assign anyGrant = |grant;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = s_arvalid_i[i] && (outstCnt_q[i] < 4'(MAX_OUTST));
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .en_i    (loadOk),
    .grant_o (grant)
  );

  assign s_arready_o = grant;

  always_comb begin
    arD      = '0;
    grantIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grantIdx   = IDX_W'(i);
        arD.addr   = s_araddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        arD.id     = {RIDX_W'(i), s_arid_i[i*ID_IN_WIDTH +: ID_IN_WIDTH]};
        arD.len    = s_arlen_i[i*8 +: 8];
        arD.size   = s_arsize_i[i*3 +: 3];
        arD.burst  = s_arburst_i[i*2 +: 2];
        arD.secsid = s_secsid_i[i*SECSID_WIDTH +: SECSID_WIDTH];
        arD.sid    = s_sid_i[i*SID_WIDTH +: SID_WIDTH];
        arD.ssid   = s_ssid_i[i*SSID_WIDTH +: SSID_WIDTH];
        arD.ssidv  = s_ssidv_i[i];
      end
    end
  end

  assign rIdx = m_rid_i[ID_R_WIDTH-1:ID_IN_WIDTH];

  // Decode the RID prefix by comparison so an out-of-range prefix never indexes past NUM_REQ.
  always_comb begin
    s_rvalid_o = '0;
    rReadySel  = 1'b0;
    routable   = 1'b0;
    rCnt       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rIdx == RIDX_W'(i)) begin
        routable      = 1'b1;
        s_rvalid_o[i] = m_rvalid_i;
        rReadySel     = s_rready_i[i];
        rCnt          = outstCnt_q[i];
      end
    end
  end

  assign m_rready_o = routable ? rReadySel : 1'b1;
  assign rHs        = m_rvalid_i && m_rready_o;
  assign lastHs     = rHs && m_rlast_i && routable;
  assign s_rid_o    = m_rid_i[ID_IN_WIDTH-1:0];
  assign s_rdata_o  = m_rdata_i;
  assign s_rresp_o  = m_rresp_i;
  assign s_rlast_o  = m_rlast_i;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      logic inc, dec;
      inc           = grant[i];
      dec           = lastHs && (rIdx == RIDX_W'(i)) && (outstCnt_q[i] != 4'd0);
      outstCnt_d[i] = outstCnt_q[i];
      if (inc && !dec && outstCnt_q[i] != 4'hF) begin
        outstCnt_d[i] = outstCnt_q[i] + 4'd1;
      end else if (dec && !inc) begin
        outstCnt_d[i] = outstCnt_q[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      arQ             <= '0;
      mArvalid_q      <= 1'b0;
      ptr_q           <= '0;
      errUnroutable_q <= 1'b0;
      errUnderflow_q  <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        outstCnt_q[i] <= '0;
      end
    end else begin
      if (anyGrant) begin
        arQ        <= arD;
        mArvalid_q <= 1'b1;
        ptr_q      <= grantIdx + IDX_W'(1);
      end else if (m_arready_i) begin
        mArvalid_q <= 1'b0;
      end
      errUnroutable_q <= rHs && !routable;
      errUnderflow_q  <= lastHs && (rCnt == 4'd0);
      for (int i = 0; i < NUM_REQ; i++) begin
        outstCnt_q[i] <= outstCnt_d[i];
      end
    end
  end

  assign m_arvalid_o      = mArvalid_q;
  assign m_araddr_o       = arQ.addr;
  assign m_arid_o         = arQ.id;
  assign m_arlen_o        = arQ.len;
  assign m_arsize_o       = arQ.size;
  assign m_arburst_o      = arQ.burst;
  assign m_arsecsid_o     = arQ.secsid;
  assign m_arsid_o        = arQ.sid;
  assign m_arssid_o       = arQ.ssid;
  assign m_arssidv_o      = arQ.ssidv;
  assign err_unroutable_o = errUnroutable_q;
  assign err_underflow_o  = errUnderflow_q;

endmodule

// File: tb/tb_axi_ar_sid_arbiter.sv
// Directed bench for axi_ar_sid_arbiter: a vector table for grant order and R routing,
// then hand-written sequences for backpressure, masking, underflow and reset.
module tb_axi_ar_sid_arbiter;

  localparam int N = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic [N-1:0]  s_arvalid, s_arready;
  logic [N*16-1:0] s_araddr;
  logic [N*2-1:0]  s_arid;
  logic [N*8-1:0]  s_arlen;
  logic [N*3-1:0]  s_arsize;
  logic [N*2-1:0]  s_arburst;
  logic [N*1-1:0]  s_secsid;
  logic [N*3-1:0]  s_sid;
  logic [N*6-1:0]  s_ssid;
  logic [N-1:0]    s_ssidv;
  logic          m_arvalid, m_arready;
  logic [15:0]   m_araddr;
  logic [3:0]    m_arid;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic [0:0]    m_arsecsid;
  logic [2:0]    m_arsid;
  logic [5:0]    m_arssid;
  logic          m_arssidv;
  logic          m_rvalid, m_rready;
  logic [3:0]    m_rid;
  logic [31:0]   m_rdata;
  logic [2:0]    m_rresp;
  logic          m_rlast;
  logic [N-1:0]  s_rvalid, s_rready;
  logic [1:0]    s_rid;
  logic [31:0]   s_rdata;
  logic [2:0]    s_rresp;
  logic          s_rlast;
  logic          err_unroutable, err_underflow;

  int vecCount  = 0;
  int missCount = 0;

  axi_ar_sid_arbiter dut (
    .aclk_i(aclk), .areset_i(areset),
    .s_arvalid_i(s_arvalid), .s_arready_o(s_arready), .s_araddr_i(s_araddr),
    .s_arid_i(s_arid), .s_arlen_i(s_arlen), .s_arsize_i(s_arsize), .s_arburst_i(s_arburst),
    .s_secsid_i(s_secsid), .s_sid_i(s_sid), .s_ssid_i(s_ssid), .s_ssidv_i(s_ssidv),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr),
    .m_arid_o(m_arid), .m_arlen_o(m_arlen), .m_arsize_o(m_arsize), .m_arburst_o(m_arburst),
    .m_arsecsid_o(m_arsecsid), .m_arsid_o(m_arsid), .m_arssid_o(m_arssid),
    .m_arssidv_o(m_arssidv),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rid_i(m_rid), .m_rdata_i(m_rdata),
    .m_rresp_i(m_rresp), .m_rlast_i(m_rlast),
    .s_rvalid_o(s_rvalid), .s_rready_i(s_rready), .s_rid_o(s_rid), .s_rdata_o(s_rdata),
    .s_rresp_o(s_rresp), .s_rlast_o(s_rlast),
    .err_unroutable_o(err_unroutable), .err_underflow_o(err_underflow)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0] arvalid;
    logic       arready;
    logic       rvalid;
    logic [3:0] rid;
    logic       rlast;
    logic [3:0] srready;
    logic [3:0] expArready;
    logic       expMArvalid;
    logic [3:0] expMArid;
    logic [3:0] expSRvalid;
    logic       expMRready;
    logic [1:0] expSRid;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    s_arvalid = v.arvalid;
    m_arready = v.arready;
    m_rvalid  = v.rvalid;
    m_rid     = v.rid;
    m_rlast   = v.rlast;
    s_rready  = v.srready;
  endtask

  task automatic clearInputs();
    s_arvalid = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rid     = '0;
    m_rlast   = 1'b0;
    s_rready  = '0;
  endtask

  task automatic doReset();
    areset = 1'b1;
    clearInputs();
    tick();
    tick();
    areset = 1'b0;
  endtask

  initial begin
    areset  = 1'b1;
    clearInputs();
    m_rdata = 32'hA5A5_0000;
    m_rresp = 3'd0;
    for (int i = 0; i < N; i++) begin
      s_araddr[i*16 +: 16] = 16'((i + 1) << 12);
      s_arid[i*2 +: 2]     = 2'(3 - i);
      s_arlen[i*8 +: 8]    = 8'(i);
      s_arsize[i*3 +: 3]   = 3'd2;
      s_arburst[i*2 +: 2]  = 2'd1;
      s_secsid[i]          = 1'(i & 1);
      s_sid[i*3 +: 3]      = 3'(i + 3);
      s_ssid[i*6 +: 6]     = 6'(i * 5);
      s_ssidv[i]           = 1'b1;
    end

    //            arv   ard   rv    rid   rl    srr    expAr mv    mid   srv   mrr   srid
    vecs[0]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0};
    vecs[1]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h2, 1'b1, 4'h3, 4'h0, 1'b0, 2'd0};
    vecs[2]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h4, 1'b1, 4'h6, 4'h0, 1'b0, 2'd0};
    vecs[3]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h8, 1'b1, 4'h9, 4'h0, 1'b0, 2'd0};
    vecs[4]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h1, 1'b1, 4'hC, 4'h0, 1'b0, 2'd0};
    vecs[5]  = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h3, 4'h0, 1'b0, 2'd0};
    vecs[6]  = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h3, 4'h0, 1'b0, 2'd0};
    vecs[7]  = '{4'h0, 1'b0, 1'b1, 4'hE, 1'b0, 4'h7, 4'h0, 1'b0, 4'h3, 4'h8, 1'b0, 2'd2};
    vecs[8]  = '{4'h0, 1'b0, 1'b1, 4'hE, 1'b0, 4'hF, 4'h0, 1'b0, 4'h3, 4'h8, 1'b1, 2'd2};
    vecs[9]  = '{4'h0, 1'b0, 1'b1, 4'h5, 1'b1, 4'h2, 4'h0, 1'b0, 4'h3, 4'h2, 1'b1, 2'd1};
    vecs[10] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h3, 4'h0, 1'b0, 2'd0};

    // Reset state
    doReset();
    #1;
    checkOutput("rst.m_arvalid", 32'(m_arvalid), 32'd0);
    checkOutput("rst.s_arready", 32'(s_arready), 32'd0);
    checkOutput("rst.s_rvalid", 32'(s_rvalid), 32'd0);
    checkOutput("rst.m_arid", 32'(m_arid), 32'd0);
    checkOutput("rst.m_araddr", 32'(m_araddr), 32'd0);
    checkOutput("rst.err_unroutable", 32'(err_unroutable), 32'd0);
    checkOutput("rst.err_underflow", 32'(err_underflow), 32'd0);

    // Grant order and R routing table
    for (int k = 0; k < 11; k++) begin
      applyStimulus(vecs[k]);
      #1;
      checkOutput($sformatf("v%0d.s_arready", k), 32'(s_arready), 32'(vecs[k].expArready));
      checkOutput($sformatf("v%0d.m_arvalid", k), 32'(m_arvalid), 32'(vecs[k].expMArvalid));
      checkOutput($sformatf("v%0d.m_arid", k), 32'(m_arid), 32'(vecs[k].expMArid));
      checkOutput($sformatf("v%0d.s_rvalid", k), 32'(s_rvalid), 32'(vecs[k].expSRvalid));
      checkOutput($sformatf("v%0d.m_rready", k), 32'(m_rready), 32'(vecs[k].expMRready));
      checkOutput($sformatf("v%0d.s_rid", k), 32'(s_rid), 32'(vecs[k].expSRid));
      if (k == 8) checkOutput("v8.s_rdata", s_rdata, 32'hA5A5_0000);
      tick();
    end

    // Single request from requester 2
    doReset();
    s_arvalid = 4'b0100;
    #1;
    checkOutput("single.s_arready", 32'(s_arready), 32'h4);
    checkOutput("single.m_arvalid_pre", 32'(m_arvalid), 32'd0);
    tick();
    checkOutput("single.m_arvalid", 32'(m_arvalid), 32'd1);
    checkOutput("single.m_arid", 32'(m_arid), 32'h9);
    checkOutput("single.m_arsid", 32'(m_arsid), 32'd5);
    checkOutput("single.m_araddr", 32'(m_araddr), 32'h3000);
    checkOutput("single.blocked", 32'(s_arready), 32'd0);

    // Backpressure for 5 cycles, then release
    doReset();
    s_arvalid = 4'hF;
    #1;
    tick();
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp%0d.s_arready", c), 32'(s_arready), 32'd0);
      checkOutput($sformatf("bp%0d.m_arvalid", c), 32'(m_arvalid), 32'd1);
      checkOutput($sformatf("bp%0d.m_arid", c), 32'(m_arid), 32'h3);
      checkOutput($sformatf("bp%0d.m_araddr", c), 32'(m_araddr), 32'h1000);
      tick();
    end
    m_arready = 1'b1;
    #1;
    checkOutput("bp.release_grant", 32'(s_arready), 32'h2);
    tick();
    checkOutput("bp.next_arid", 32'(m_arid), 32'h6);
    checkOutput("bp.next_valid", 32'(m_arvalid), 32'd1);

    // Requester 1 reaches its outstanding limit and is skipped
    doReset();
    s_arvalid = 4'b0010;
    m_arready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput($sformatf("lim%0d.s_arready", c), 32'(s_arready), 32'h2);
      tick();
    end
    s_arvalid = 4'hF;
    #1;
    checkOutput("skip0.s_arready", 32'(s_arready), 32'h4);
    tick();
    checkOutput("skip1.s_arready", 32'(s_arready), 32'h8);
    tick();
    checkOutput("skip2.s_arready", 32'(s_arready), 32'h1);
    tick();
    checkOutput("skip3.s_arready", 32'(s_arready), 32'h4);
    tick();
    s_arvalid = 4'b0010;
    m_rvalid  = 1'b1;
    m_rid     = 4'h5;
    m_rlast   = 1'b1;
    s_rready  = 4'b0010;
    #1;
    checkOutput("masked.s_arready", 32'(s_arready), 32'd0);
    checkOutput("rlast.m_rready", 32'(m_rready), 32'd1);
    checkOutput("rlast.s_rvalid", 32'(s_rvalid), 32'h2);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    checkOutput("unmasked.s_arready", 32'(s_arready), 32'h2);

    // RLAST with zero outstanding
    doReset();
    m_rvalid = 1'b1;
    m_rid    = 4'h8;
    m_rlast  = 1'b1;
    s_rready = 4'b0100;
    #1;
    checkOutput("uf.m_rready", 32'(m_rready), 32'd1);
    checkOutput("uf.pre", 32'(err_underflow), 32'd0);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    checkOutput("uf.pulse", 32'(err_underflow), 32'd1);
    checkOutput("uf.unroutable", 32'(err_unroutable), 32'd0);
    tick();
    checkOutput("uf.post", 32'(err_underflow), 32'd0);
    s_arvalid = 4'b0100;
    m_arready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput($sformatf("uf.cnt%0d", c), 32'(s_arready), 32'h4);
      tick();
    end
    checkOutput("uf.limit", 32'(s_arready), 32'd0);

    // Reset while the output register is full
    s_arvalid = 4'b0001;
    #1;
    checkOutput("rf.load", 32'(s_arready), 32'h1);
    tick();
    m_arready = 1'b0;
    #1;
    checkOutput("rf.full", 32'(m_arvalid), 32'd1);
    checkOutput("rf.arid", 32'(m_arid), 32'h3);
    areset = 1'b1;
    #1;
    checkOutput("rf.in_reset_ready", 32'(s_arready), 32'd0);
    tick();
    checkOutput("rf.m_arvalid", 32'(m_arvalid), 32'd0);
    checkOutput("rf.m_arid", 32'(m_arid), 32'd0);
    areset    = 1'b0;
    m_arready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput($sformatf("rf.cnt%0d", c), 32'(s_arready), 32'h1);
      tick();
    end
    checkOutput("rf.limit", 32'(s_arready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
